// File: rtl/draw_layer_scheduler.sv
// Per-frame scheduler sharing one sprite-draw engine between NUM_LAYERS layers, painted bottom-up.
// Optional macro DRAW_SCHED_FRAME_CYCLES_EN adds the lastFrameCycles measurement output.
module draw_layer_scheduler #(
    parameter int NUM_LAYERS     = 4,
    parameter int X_BITS         = 8,
    parameter int Y_BITS         = 9,
    parameter int ID_BITS        = 4,
    parameter int TIMEOUT_CYCLES = 4194304
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          frameTick,
    input  logic                          errClear,
    input  logic [NUM_LAYERS-1:0]         layerEnable,
    input  logic [NUM_LAYERS*X_BITS-1:0]  layerX,
    input  logic [NUM_LAYERS*Y_BITS-1:0]  layerY,
    input  logic [NUM_LAYERS*ID_BITS-1:0] layerRomId,
    input  logic                          drawReady,
    output logic                          drawStart,
    output logic [X_BITS-1:0]             drawX,
    output logic [Y_BITS-1:0]             drawY,
    output logic [ID_BITS-1:0]            drawRomId,
    output logic                          busy,
    output logic [2:0]                    layerIndex,
    output logic                          frameDone,
    output logic                          overrunError,
    output logic                          timeoutError
`ifdef DRAW_SCHED_FRAME_CYCLES_EN
    ,
    output logic [23:0]                   lastFrameCycles
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ISSUE, S_WAIT_DONE, S_DONE} state_t;

    localparam logic [2:0]  LAST_IDX = 3'(NUM_LAYERS - 1);
    localparam logic [22:0] TO_LAST  = 23'(TIMEOUT_CYCLES - 1);

    state_t                          state_q, state_d;
    logic [2:0]                      idx_q, idx_d;
    logic                            start_q, start_d;
    logic [X_BITS-1:0]               x_q, x_d;
    logic [Y_BITS-1:0]               y_q, y_d;
    logic [ID_BITS-1:0]              id_q, id_d;
    logic [22:0]                     cnt_q, cnt_d;
    logic                            overrun_q, overrun_d;
    logic                            timeout_err_q, timeout_err_d;
    logic                            tick_prev_q;
    logic [NUM_LAYERS-1:0]           snap_en_q;
    logic [NUM_LAYERS*X_BITS-1:0]    snap_x_q;
    logic [NUM_LAYERS*Y_BITS-1:0]    snap_y_q;
    logic [NUM_LAYERS*ID_BITS-1:0]   snap_id_q;
    logic [7:0]                      snap_en_ext;
    logic                            tick_edge, snap_load, timeout_hit, advance;
    logic                            last_layer, cnt_expired;

    assign tick_edge   = frameTick & ~tick_prev_q;
    assign snap_en_ext = 8'(snap_en_q);
    assign last_layer  = (idx_q == LAST_IDX);
    assign cnt_expired = (cnt_q == TO_LAST);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        start_d     = start_q;
        x_d         = x_q;
        y_d         = y_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        snap_load   = 1'b0;
        timeout_hit = 1'b0;
        advance     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick_edge) begin
                    snap_load = 1'b1;
                    idx_d     = 3'd0;
                    state_d   = S_SELECT;
                end
            end
            S_SELECT: begin
                if (snap_en_ext[idx_q]) begin
                    x_d     = snap_x_q[int'(idx_q)*X_BITS +: X_BITS];
                    y_d     = snap_y_q[int'(idx_q)*Y_BITS +: Y_BITS];
                    id_d    = snap_id_q[int'(idx_q)*ID_BITS +: ID_BITS];
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end else if (last_layer) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + 23'd1;
                if (cnt_expired) begin
                    start_d     = 1'b0;
                    timeout_hit = 1'b1;
                    advance     = 1'b1;
                end else if (!start_q && drawReady) begin
                    start_d = 1'b1;
                end else if (start_q && !drawReady) begin
                    // Engine has accepted the request once it drops ready.
                    start_d = 1'b0;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                cnt_d = cnt_q + 23'd1;
                if (drawReady) begin
                    advance = 1'b1;
                end else if (cnt_expired) begin
                    timeout_hit = 1'b1;
                    advance     = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (advance) begin
            if (last_layer) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + 3'd1;
                state_d = S_SELECT;
            end
        end
    end

    // A new error in the same cycle as errClear keeps the flag set.
    assign overrun_d     = (overrun_q & ~errClear) | (tick_edge & (state_q != S_IDLE));
    assign timeout_err_d = (timeout_err_q & ~errClear) | timeout_hit;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= 3'd0;
            start_q       <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            id_q          <= '0;
            cnt_q         <= '0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            snap_en_q     <= '0;
            snap_x_q      <= '0;
            snap_y_q      <= '0;
            snap_id_q     <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            start_q       <= start_d;
            x_q           <= x_d;
            y_q           <= y_d;
            id_q          <= id_d;
            cnt_q         <= cnt_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
            if (snap_load) begin
                snap_en_q <= layerEnable;
                snap_x_q  <= layerX;
                snap_y_q  <= layerY;
                snap_id_q <= layerRomId;
            end
        end
    end

    // Tracking frameTick during reset means a tick held high across reset is not an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) tick_prev_q <= frameTick;
        else       tick_prev_q <= frameTick;
    end

    assign drawStart    = start_q;
    assign drawX        = x_q;
    assign drawY        = y_q;
    assign drawRomId    = id_q;
    assign busy         = (state_q == S_SELECT) || (state_q == S_ISSUE) || (state_q == S_WAIT_DONE);
    assign layerIndex   = idx_q;
    assign frameDone    = (state_q == S_DONE);
    assign overrunError = overrun_q;
    assign timeoutError = timeout_err_q;

`ifdef DRAW_SCHED_FRAME_CYCLES_EN
    logic [23:0] frame_cyc_q, frame_cyc_d, last_cyc_q, last_cyc_d, frame_cyc_inc;

    assign frame_cyc_inc = (frame_cyc_q == 24'hFFFFFF) ? frame_cyc_q : frame_cyc_q + 24'd1;

    always_comb begin
        frame_cyc_d = frame_cyc_q;
        last_cyc_d  = last_cyc_q;
        if ((state_q == S_IDLE) && tick_edge) frame_cyc_d = 24'd1;
        else if (state_q == S_DONE)           last_cyc_d  = frame_cyc_inc;
        else if (busy)                        frame_cyc_d = frame_cyc_inc;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cyc_q <= '0;
            last_cyc_q  <= '0;
        end else begin
            frame_cyc_q <= frame_cyc_d;
            last_cyc_q  <= last_cyc_d;
        end
    end

    assign lastFrameCycles = last_cyc_q;
`endif

endmodule

// File: tb/tb_draw_layer_scheduler.sv
// Self-checking bench for draw_layer_scheduler: table-driven frames, a draw scoreboard and
// hand-written overrun / timeout / mid-frame reset sequences against a behavioural engine.
module tb_draw_layer_scheduler;

    localparam int NL = 4;
    localparam int XB = 8;
    localparam int YB = 9;
    localparam int IB = 4;
    localparam int TO = 64;

    logic              clock = 1'b0;
    logic              reset;
    logic              frameTick;
    logic              errClear;
    logic [NL-1:0]     layerEnable;
    logic [NL*XB-1:0]  layerX;
    logic [NL*YB-1:0]  layerY;
    logic [NL*IB-1:0]  layerRomId;
    logic              drawReady;
    logic              drawStart;
    logic [XB-1:0]     drawX;
    logic [YB-1:0]     drawY;
    logic [IB-1:0]     drawRomId;
    logic              busy;
    logic [2:0]        layerIndex;
    logic              frameDone;
    logic              overrunError;
    logic              timeoutError;
`ifdef DRAW_SCHED_FRAME_CYCLES_EN
    logic [23:0]       lastFrameCycles;
`endif

    draw_layer_scheduler #(
        .NUM_LAYERS(NL), .X_BITS(XB), .Y_BITS(YB), .ID_BITS(IB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .frameTick(frameTick), .errClear(errClear),
        .layerEnable(layerEnable), .layerX(layerX), .layerY(layerY), .layerRomId(layerRomId),
        .drawReady(drawReady), .drawStart(drawStart), .drawX(drawX), .drawY(drawY),
        .drawRomId(drawRomId), .busy(busy), .layerIndex(layerIndex), .frameDone(frameDone),
        .overrunError(overrunError), .timeoutError(timeoutError)
`ifdef DRAW_SCHED_FRAME_CYCLES_EN
        , .lastFrameCycles(lastFrameCycles)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [NL-1:0]    en;
        logic [NL*XB-1:0] x;
        logic [NL*YB-1:0] y;
        logic [NL*IB-1:0] id;
        int               stuck;
        int               exp_draws;
        logic             exp_timeout;
    } vec_t;

    typedef struct packed {
        logic [2:0]    idx;
        logic [XB-1:0] x;
        logic [YB-1:0] y;
        logic [IB-1:0] id;
    } draw_t;

    draw_t exp_q[$];
    int    checks      = 0;
    int    errors      = 0;
    int    cyc         = 0;
    int    starts      = 0;
    int    done_cnt    = 0;
    int    done_cyc    = 0;
    int    to_cyc      = 0;
    int    start_cyc [8];
    int    stuck_layer = -1;
    int    hold_cycles = 50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Engine model: drops ready 3 cycles after seeing a request, holds it low hold_cycles.
    initial begin : engine
        drawReady = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (drawStart && drawReady && int'(layerIndex) != stuck_layer) begin
                repeat (3) @(posedge clock);
                #1 drawReady = 1'b0;
                repeat (hold_cycles) @(posedge clock);
                #1 drawReady = 1'b1;
            end
        end
    end

    // Scoreboard side: every rising drawStart must match the next expected draw.
    initial begin : monitor
        draw_t d;
        logic  start_prev;
        logic  to_prev;
        start_prev = 1'b0;
        to_prev    = 1'b0;
        forever begin
            @(negedge clock);
            if (drawStart && !start_prev) begin
                starts++;
                start_cyc[layerIndex] = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_draw_layer", 32'(layerIndex), 32'hFFFF_FFFF);
                end else begin
                    d = exp_q.pop_front();
                    check("draw_layer", 32'(layerIndex), 32'(d.idx));
                    check("draw_x", 32'(drawX), 32'(d.x));
                    check("draw_y", 32'(drawY), 32'(d.y));
                    check("draw_romid", 32'(drawRomId), 32'(d.id));
                end
            end
            start_prev = drawStart;
            if (timeoutError && !to_prev) to_cyc = cyc;
            to_prev = timeoutError;
            if (frameDone) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_frame(input vec_t v, output int t0, output int d0);
        layerEnable = v.en;
        layerX      = v.x;
        layerY      = v.y;
        layerRomId  = v.id;
        stuck_layer = v.stuck;
        starts      = 0;
        for (int i = 0; i < NL; i++)
            if (v.en[i])
                exp_q.push_back('{idx: 3'(i), x: v.x[i*XB +: XB], y: v.y[i*YB +: YB],
                                  id: v.id[i*IB +: IB]});
        d0 = done_cnt;
        @(posedge clock);
        #1 frameTick = 1'b1;
        t0 = cyc;
        @(posedge clock);
        #1;
        layerEnable = ~v.en;
        layerX      = ~v.x;
        layerY      = ~v.y;
        layerRomId  = ~v.id;
        repeat (2) @(posedge clock);
        #1 frameTick = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        for (int c = 0; c < 3000 && done_cnt == d0; c++) @(negedge clock);
        if (done_cnt == d0) check({tag, "_frame_end_wait"}, 32'(done_cnt), 32'(d0 + 1));
        repeat (3) @(negedge clock);
    endtask

    task automatic pulse_clear();
        @(posedge clock);
        #1 errClear = 1'b1;
        @(posedge clock);
        #1 errClear = 1'b0;
        @(negedge clock);
    endtask

    vec_t vecs [5];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int    t0, d0;
        string tag;

        vecs[0] = '{4'b1111, {8'h40, 8'h30, 8'h20, 8'h10}, {9'h1A0, 9'h0F0, 9'h055, 9'h100},
                    {4'd6, 4'd2, 4'd5, 4'd15}, -1, 4, 1'b0};
        vecs[1] = '{4'b0101, {8'hC3, 8'hB2, 8'hA1, 8'h90}, {9'h003, 9'h102, 9'h1FF, 9'h000},
                    {4'd9, 4'd10, 4'd11, 4'd12}, -1, 2, 1'b0};
        vecs[2] = '{4'b0000, {8'h11, 8'h22, 8'h33, 8'h44}, {9'h011, 9'h022, 9'h033, 9'h044},
                    {4'd1, 4'd2, 4'd3, 4'd4}, -1, 0, 1'b0};
        vecs[3] = '{4'b1010, {8'hFF, 8'h01, 8'h7E, 8'h80}, {9'h0AA, 9'h155, 9'h001, 9'h1FE},
                    {4'd0, 4'd15, 4'd3, 4'd12}, -1, 2, 1'b0};
        vecs[4] = '{4'b1111, {8'h05, 8'h06, 8'h07, 8'h08}, {9'h105, 9'h106, 9'h107, 9'h108},
                    {4'd7, 4'd8, 4'd9, 4'd10}, 1, 4, 1'b1};

        reset       = 1'b1;
        frameTick   = 1'b1;
        errClear    = 1'b0;
        layerEnable = '0;
        layerX      = '0;
        layerY      = '0;
        layerRomId  = '0;
        repeat (3) @(negedge clock);
        check("rst_drawStart", 32'(drawStart), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frameDone", 32'(frameDone), 32'd0);
        check("rst_layerIndex", 32'(layerIndex), 32'd0);
        check("rst_errors", 32'({overrunError, timeoutError}), 32'd0);
        check("rst_draw_outputs", 32'({drawX, drawY, drawRomId}), 32'd0);
`ifdef DRAW_SCHED_FRAME_CYCLES_EN
        check("rst_lastFrameCycles", 32'(lastFrameCycles), 32'd0);
`endif
        #1 reset = 1'b0;
        repeat (5) @(negedge clock);
        check("no_spurious_frame_busy", 32'(busy), 32'd0);
        check("no_spurious_frame_done", 32'(done_cnt), 32'd0);
        frameTick = 1'b0;
        repeat (2) @(negedge clock);

        for (int v = 0; v < 5; v++) begin
            tag = $sformatf("vec%0d", v);
            start_frame(vecs[v], t0, d0);
            wait_done(tag, d0);
            check({tag, "_frameDone_count"}, 32'(done_cnt - d0), 32'd1);
            check({tag, "_busy_after"}, 32'(busy), 32'd0);
            check({tag, "_drawStart_count"}, 32'(starts), 32'(vecs[v].exp_draws));
            check({tag, "_draws_left"}, 32'(exp_q.size()), 32'd0);
            check({tag, "_timeoutError"}, 32'(timeoutError), 32'(vecs[v].exp_timeout));
            if (vecs[v].en == '0) begin
                check({tag, "_empty_latency_ok"}, 32'((done_cyc - t0) <= NL + 3), 32'd1);
`ifdef DRAW_SCHED_FRAME_CYCLES_EN
                check({tag, "_lastFrameCycles"}, 32'(lastFrameCycles), 32'(NL + 2));
`endif
            end
            if (vecs[v].exp_timeout) begin
                check({tag, "_timeout_delay_ok"},
                      32'(((to_cyc - start_cyc[1]) >= TO - 4) && ((to_cyc - start_cyc[1]) <= TO + 2)),
                      32'd1);
            end
            pulse_clear();
            check({tag, "_timeoutError_cleared"}, 32'(timeoutError), 32'd0);
            exp_q.delete();
        end

        // Overrun: extra ticks during layers 2 and 3 must flag but not disturb the frame.
        start_frame(vecs[0], t0, d0);
        for (int c = 0; c < 3000 && !(layerIndex == 3'd2 && busy); c++) @(negedge clock);
        check("ovr_reach_layer2", 32'(layerIndex), 32'd2);
        @(posedge clock);
        #1 frameTick = 1'b1;
        repeat (2) @(negedge clock);
        check("ovr_flag_set", 32'(overrunError), 32'd1);
        check("ovr_still_busy", 32'(busy), 32'd1);
        check("ovr_layer_unchanged", 32'(layerIndex), 32'd2);
        #1 frameTick = 1'b0;
        for (int c = 0; c < 3000 && layerIndex != 3'd3; c++) @(negedge clock);
        check("ovr_reach_layer3", 32'(layerIndex), 32'd3);
        @(posedge clock);
        #1;
        frameTick = 1'b1;
        errClear  = 1'b1;
        @(posedge clock);
        #1;
        errClear  = 1'b0;
        frameTick = 1'b0;
        @(negedge clock);
        check("ovr_error_beats_clear", 32'(overrunError), 32'd1);
        wait_done("ovr", d0);
        check("ovr_frameDone_count", 32'(done_cnt - d0), 32'd1);
        check("ovr_drawStart_count", 32'(starts), 32'd4);
        check("ovr_draws_left", 32'(exp_q.size()), 32'd0);
        pulse_clear();
        check("ovr_flag_cleared", 32'(overrunError), 32'd0);

        // Reset while a request is being presented.
        start_frame(vecs[0], t0, d0);
        for (int c = 0; c < 3000 && !drawStart; c++) @(negedge clock);
        check("rst_issue_reach", 32'(drawStart), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_issue_drawStart_async", 32'(drawStart), 32'd0);
        check("rst_issue_busy_async", 32'(busy), 32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        exp_q.delete();
        repeat (70) @(negedge clock);
        check("rst_issue_no_frameDone", 32'(done_cnt - d0), 32'd0);

        // Reset while waiting for the engine to finish.
        start_frame(vecs[0], t0, d0);
        for (int c = 0; c < 3000 && !drawStart; c++) @(negedge clock);
        for (int c = 0; c < 3000 && drawStart; c++) @(negedge clock);
        repeat (5) @(negedge clock);
        check("rst_wait_reach_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_wait_drawStart_async", 32'(drawStart), 32'd0);
        check("rst_wait_busy_async", 32'(busy), 32'd0);
        check("rst_wait_layerIndex_async", 32'(layerIndex), 32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        exp_q.delete();
        repeat (70) @(negedge clock);
        check("rst_wait_no_frameDone", 32'(done_cnt - d0), 32'd0);
        check("rst_wait_idle_after", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
